// File: rtl/array_add_pkg.sv
// -----------------------------------------------------------------------------
// array_add_pkg
// Shared constants and types for the array_add streaming adder.
//   DEF_ADDR_W : default memory address width
//   DEF_DATA_W : default element width
//   DEF_N      : default number of elements per run
//   state_t    : controller state encoding (IDLE, RUN, DRAIN)
// -----------------------------------------------------------------------------
package array_add_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_N      = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/array_add_ctrl.sv
// -----------------------------------------------------------------------------
// array_add_ctrl
// Run controller for array_add: FSM plus element index counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   tstart     : start request, honoured only in IDLE
//   rd_en      : read strobe shared by both operand memories
//   rd_addr    : read address (0 when rd_en is low)
//   wr_en      : write strobe, rd_en delayed by one cycle
//   wr_addr    : write address, rd_addr delayed by one cycle
//   last       : high in the cycle carrying the final write
// -----------------------------------------------------------------------------
module array_add_ctrl
  import array_add_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last
);

  // One extra bit so that N = 2**ADDR_W still has a distinct terminal index.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_nxt;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (tstart) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = DRAIN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + CNT_W'(1);
        end
      end
      DRAIN: begin
        // tstart is deliberately not looked at here: a new run needs IDLE.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Read strobe decoded from the state register, so reset drops it at once.
  assign rd_en   = (state == RUN);
  assign rd_addr = rd_en ? idx[ADDR_W-1:0] : '0;
  assign last    = (state == DRAIN);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      // Write side trails the read side by the one-cycle memory latency.
      wr_en   <= rd_en;
      wr_addr <= rd_addr;
    end
  end

endmodule

// File: rtl/array_add.sv
// -----------------------------------------------------------------------------
// array_add
// Streaming element-wise adder: v2[i] = v0[i] + v1[i], i = 0..N-1, over three
// external single-port memories with 1-cycle read latency.
//   clk, rst_n           : clock, asynchronous active-low reset
//   tstart               : start pulse, accepted only when idle
//   v0_addr / v0_rd_en   : operand memory 0 read port
//   v0_rd_data           : operand memory 0 data, valid the cycle after rd_en
//   v1_addr / v1_rd_en   : operand memory 1 read port
//   v1_rd_data           : operand memory 1 data, valid the cycle after rd_en
//   v2_addr / v2_wr_en   : result memory write port
//   v2_wr_data           : result data (0 whenever v2_wr_en is low)
//   done                 : one-cycle pulse with the final write
// -----------------------------------------------------------------------------
module array_add
  import array_add_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tstart,
  output logic [ADDR_W-1:0] v0_addr,
  output logic              v0_rd_en,
  input  logic [DATA_W-1:0] v0_rd_data,
  output logic [ADDR_W-1:0] v1_addr,
  output logic              v1_rd_en,
  input  logic [DATA_W-1:0] v1_rd_data,
  output logic [ADDR_W-1:0] v2_addr,
  output logic              v2_wr_en,
  output logic [DATA_W-1:0] v2_wr_data,
  output logic              done
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              last;

  array_add_ctrl #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .tstart  (tstart),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .last    (last)
  );

  assign v0_rd_en = rd_en;
  assign v1_rd_en = rd_en;
  assign v0_addr  = rd_addr;
  assign v1_addr  = rd_addr;

  assign v2_wr_en = wr_en;
  assign v2_addr  = wr_addr;
  // Sum of the data returned this cycle; carry-out is dropped (mod 2**DATA_W).
  assign v2_wr_data = wr_en ? (v0_rd_data + v1_rd_data) : '0;
  assign done       = wr_en & last;

endmodule

// File: tb/tb_array_add.sv
// -----------------------------------------------------------------------------
// tb_array_add
// Self-checking bench for array_add. Operand memories are modelled either as
// incrementing counters or constants; expected writes are queued per run and
// compared as the DUT writes them.
// -----------------------------------------------------------------------------
module tb_array_add;

  localparam int N      = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef struct {
    logic        inc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] base;
    logic [31:0] step;
    string       name;
  } vec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tstart;
  logic [ADDR_W-1:0] v0_addr;
  logic              v0_rd_en;
  logic [DATA_W-1:0] v0_rd_data = '0;
  logic [ADDR_W-1:0] v1_addr;
  logic              v1_rd_en;
  logic [DATA_W-1:0] v1_rd_data = '0;
  logic [ADDR_W-1:0] v2_addr;
  logic              v2_wr_en;
  logic [DATA_W-1:0] v2_wr_data;
  logic              done;

  array_add #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tstart     (tstart),
    .v0_addr    (v0_addr),
    .v0_rd_en   (v0_rd_en),
    .v0_rd_data (v0_rd_data),
    .v1_addr    (v1_addr),
    .v1_rd_en   (v1_rd_en),
    .v1_rd_data (v1_rd_data),
    .v2_addr    (v2_addr),
    .v2_wr_en   (v2_wr_en),
    .v2_wr_data (v2_wr_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Operand memory model: registered read data, 1-cycle latency.
  logic        load = 1'b0;
  logic        inc_mode = 1'b1;
  logic [31:0] seed0 = '0;
  logic [31:0] seed1 = '0;
  logic [31:0] m0_cnt = '0;
  logic [31:0] m1_cnt = '0;

  always @(posedge clk) begin
    if (load) begin
      m0_cnt <= seed0;
      m1_cnt <= seed1;
    end else begin
      if (v0_rd_en) begin
        if (inc_mode) begin
          m0_cnt     <= m0_cnt + 32'd1;
          v0_rd_data <= m0_cnt + 32'd1;
        end else begin
          v0_rd_data <= seed0;
        end
      end
      if (v1_rd_en) begin
        if (inc_mode) begin
          m1_cnt     <= m1_cnt + 32'd1;
          v1_rd_data <= m1_cnt + 32'd1;
        end else begin
          v1_rd_data <= seed1;
        end
      end
    end
  end

  // Scoreboard and monitor, sampled on the falling edge.
  exp_t exp_q[$];
  int   wr_count   = 0;
  int   done_count = 0;
  int   rd0_cyc    = -1;
  int   wr0_cyc    = -1;
  int   done_cyc   = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_ports_agree", {v0_rd_en, v0_addr}, {v1_rd_en, v1_addr});
      if (!v0_rd_en) check("rd_addr_idle", 64'(v0_addr), 64'd0);
      if (v0_rd_en && v0_addr == '0) rd0_cyc = cyc;
      if (v2_wr_en) begin
        wr_count++;
        if (v2_addr == '0) wr0_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(v2_addr), 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(v2_addr), 64'(e.addr));
          check("wr_data", 64'(v2_wr_data), 64'(e.data));
          check("done_with_last", 64'(done), 64'(e.addr == ADDR_W'(N - 1)));
        end
      end else begin
        check("idle_wr_outputs", {v2_addr, v2_wr_data, done}, '0);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_model(input vec_t v);
    @(negedge clk);
    inc_mode = v.inc;
    seed0    = v.a;
    seed1    = v.b;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push_expected(input vec_t v);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      e.addr = ADDR_W'(k);
      e.data = v.base + v.step * 32'(k);
      exp_q.push_back(e);
    end
  endtask

  // One full run. hold: cycles tstart stays high from the accepting edge on;
  // extra: run cycle whose closing edge sees an extra tstart (-1 for none).
  task automatic run_vec(input vec_t v, input int hold, input int extra);
    int base_w, base_d, t_acc, waited;
    load_model(v);
    push_expected(v);
    base_w = wr_count;
    base_d = done_count;
    tstart = 1'b1;
    @(posedge clk);
    #2;
    t_acc  = cyc;
    waited = 0;
    while (1) begin
      tstart = ((cyc - t_acc) < hold - 1) || (extra >= 0 && cyc == t_acc + extra);
      if (done_count != base_d || waited > N + 20) break;
      @(posedge clk);
      #2;
      waited++;
    end
    tstart = 1'b0;
    check({v.name, "_timeout"}, 64'(waited <= N + 20), 64'd1);
    repeat (10) @(posedge clk);
    #2;
    check({v.name, "_write_count"}, 64'(wr_count - base_w), 64'(N));
    check({v.name, "_done_count"}, 64'(done_count - base_d), 64'd1);
    check({v.name, "_first_read_cyc"}, 64'(rd0_cyc - t_acc), 64'd0);
    check({v.name, "_first_write_cyc"}, 64'(wr0_cyc - t_acc), 64'd1);
    check({v.name, "_done_cyc"}, 64'(done_cyc - t_acc), 64'(N));
    check({v.name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int base_w, t_acc, waited;

    vecs[0] = '{1'b1, 32'd5,         32'd100,       32'd107,       32'd2, "inc_basic"};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'd0, "overflow"};
    vecs[2] = '{1'b1, 32'd0,         32'd0,         32'd2,         32'd2, "inc_zero"};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'd0, "msb_carry"};
    vecs[4] = '{1'b1, 32'hFFFF_FFF0, 32'd10,        32'hFFFF_FFFC, 32'd2, "inc_wrap"};
    vecs[5] = '{1'b0, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'd0, "const_pass"};

    rst_n  = 1'b0;
    tstart = 1'b0;
    #22;
    check("reset_outputs",
          {v0_rd_en, v1_rd_en, v2_wr_en, done, v0_addr, v1_addr, v2_addr, v2_wr_data}, '0);
    rst_n = 1'b1;

    // Idle: nothing moves without tstart.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      check("idle_outputs",
            {v0_rd_en, v1_rd_en, v2_wr_en, done, v0_addr, v1_addr, v2_addr, v2_wr_data}, '0);
    end
    check("idle_write_count", 64'(wr_count), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1, -1);

    // tstart mid-run, at the DRAIN->IDLE edge, and held for several cycles.
    run_vec(vecs[0], 1, 50);
    run_vec(vecs[0], 1, N);
    run_vec(vecs[2], 3, -1);

    // Abort with reset in run cycle 60.
    load_model(vecs[0]);
    push_expected(vecs[0]);
    base_w = wr_count;
    tstart = 1'b1;
    @(posedge clk);
    #2;
    tstart = 1'b0;
    t_acc  = cyc;
    waited = 0;
    while (cyc < t_acc + 60 && waited < 100) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("abort_writes_before", 64'(wr_count - base_w), 64'd59);
    rst_n = 1'b0;
    #1;
    check("abort_enables_drop", {v0_rd_en, v1_rd_en, v2_wr_en, done}, '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    base_w = wr_count;
    repeat (20) @(posedge clk);
    #2;
    check("abort_no_writes_after", 64'(wr_count - base_w), 64'd0);
    exp_q.delete();
    run_vec(vecs[0], 1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/array_add.md
Name: array_add

Overview:
- Streaming element-wise adder over three external single-port memories: v2[i] = v0[i] + v1[i] for i = 0..N-1.
- Started by a one-cycle tstart pulse.
- Issues one read per cycle to v0 and v1 in parallel, and one write per cycle to v2.
- Sits between a controller that pulses tstart and three memory banks with 1-cycle read latency.

Parameters:
- N, 128, number of elements processed per run.
- ADDR_W, 7, address width; N must not exceed 2**ADDR_W.
- DATA_W, 32, element width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tstart  in  1  start pulse, sampled on rising clk
- v0_addr  out  ADDR_W  read address, operand memory 0
- v0_rd_en  out  1  read enable, memory 0
- v0_rd_data  in  DATA_W  read data, memory 0; valid the cycle after v0_rd_en
- v1_addr  out  ADDR_W  read address, operand memory 1
- v1_rd_en  out  1  read enable, memory 1
- v1_rd_data  in  DATA_W  read data, memory 1; valid the cycle after v1_rd_en
- v2_addr  out  ADDR_W  write address, result memory
- v2_wr_en  out  1  write enable, result memory
- v2_wr_data  out  DATA_W  write data, result memory
- done  out  1  one-cycle pulse with the final write

Behaviour:
- Reset (async, rst_n=0): state IDLE. All addresses 0, v0_rd_en/v1_rd_en/v2_wr_en/done 0, v2_wr_data 0.
- States:
  - IDLE, RUN (read+write pipeline), DRAIN (last write only).
  - IDLE->RUN when tstart=1 at a clock edge.
  - RUN->DRAIN after the read of index N-1.
  - DRAIN->IDLE after one cycle.
- Cycle 0 is the first cycle after the edge that accepted tstart.
- Read side: in cycles k=0..N-1, v0_rd_en=v1_rd_en=1 and v0_addr=v1_addr=k.
- Write side:
  - In cycles k+1 (k=0..N-1), v2_wr_en=1, v2_addr=k.
  - v2_wr_data = v0_rd_data + v1_rd_data, computed combinationally from the read data present in that cycle.
  - Address and enable are registered.
- Throughput 1 element/cycle; a run occupies cycles 0..N. Latency from tstart edge to last write is N+1 cycles.
- done=1 only in cycle N, together with the write of index N-1.
- Arithmetic: unsigned add modulo 2**DATA_W; carry-out discarded.
- When not enabled:
  - Read addresses hold 0.
  - v2_addr holds 0.
  - v2_wr_data is forced to 0 whenever v2_wr_en=0.
- tstart while in RUN or DRAIN is ignored (no restart, no queueing). tstart at the DRAIN->IDLE edge is also ignored; a new run is accepted only in IDLE.
- tstart held high for several cycles in IDLE starts exactly one run. A further run starts if tstart is still high once IDLE is re-entered.
- rst_n asserted mid-run aborts immediately: enables drop asynchronously, no further writes; remaining results undefined in memory.
- Index counter is ADDR_W+1 bits wide internally, so N=2**ADDR_W terminates without wrap ambiguity.

Decomposition:
- Shared package array_add_pkg holds:
  - Default constants ADDR_W, DATA_W, N.
  - State enum typedef (IDLE, RUN, DRAIN).
- Optional sub-module array_add_ctrl: FSM plus index counter, emitting read strobe/address and the 1-cycle-delayed write strobe/address.
- The adder stays in the top level.

Test Plan:
- Basic run, incrementing memory model: v0 model starts at 5, v1 at 100, each increments on every clock edge where its rd_en=1, read data is registered. One tstart pulse -> exactly 128 writes, v2[k] = 107 + 2k (v2[0]=107, v2[127]=361), addresses 0..127 in order on consecutive cycles.
- Timing check: tstart accepted at edge T -> first read in cycle T+1, first write in cycle T+2, done high only in cycle T+129 together with the write of address 127.
- Overflow: v0=0xFFFFFFFF, v1=0x00000002 constant -> every v2_wr_data=0x00000001.
- tstart re-asserted at cycle 50 of a run -> ignored, total 128 writes. A second pulse after done -> second full run of 128 writes.
- rst_n pulsed low at cycle 60 -> all enables 0 in the same cycle, no writes afterwards. A subsequent tstart -> full run from address 0.
- Idle check: no tstart for 200 cycles after reset -> all enables, addresses, v2_wr_data and done remain 0.
